// File: rtl/perm_inverse_pkg.sv
// Shared PRNG package: word geometry and the inverse-permutation FSM states.
//   WordWidth    - width of a PRNG output word
//   RotWidth     - width of the rotation-amount field at the top of the word
//   DefaultShift - xorshift distance used by the forward output stage
package perm_inverse_pkg;

    localparam int unsigned WordWidth    = 64;
    localparam int unsigned RotWidth     = 6;
    localparam int unsigned DefaultShift = 6;
    localparam int unsigned CountWidth   = RotWidth + 1;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StUnshift,
        StDone
    } perm_state_e;

endpackage

// File: rtl/rotl64.sv
// Combinational left barrel rotator, one log2 stage per bit of the rotate amount.
//   data    - word to rotate
//   amt     - rotate-left amount
//   rotated - data rotated left by amt
module rotl64
    import perm_inverse_pkg::*;
(
    input  logic [WordWidth-1:0] data,
    input  logic [RotWidth-1:0]  amt,
    output logic [WordWidth-1:0] rotated
);

    logic [WordWidth-1:0] stage;

    always_comb begin
        stage = data;
        for (int unsigned i = 0; i < RotWidth; i++) begin
            if (amt[i]) begin
                stage = (stage << (2 ** i)) | (stage >> (WordWidth - (2 ** i)));
            end
        end
        rotated = stage;
    end

endmodule

// File: rtl/perm_inverse.sv
// Inverse of the PRNG output permutation (xorshift by SHIFT, then rotate right by the
// original top RotWidth bits). Searches all rotation amounts for a self-consistent
// candidate (highest matching amount wins), then undoes the xorshift iteratively.
// Fixed latency of 64 + UNSHIFT_ITERS cycles from accept to out_valid.
//   clk, rst        - clock, asynchronous active-low reset
//   in_valid/ready  - input handshake; in_ready only while idle
//   in_data         - permuted word y
//   out_valid/ready - output handshake; outputs held until accepted
//   out_data        - recovered word x (0 on error)
//   out_rot         - selected rotation amount (0 on error)
//   out_count       - number of self-consistent rotation amounts
//   out_err         - no rotation amount matched
module perm_inverse
    import perm_inverse_pkg::*;
#(
    parameter int unsigned SHIFT         = DefaultShift,
    parameter int unsigned UNSHIFT_ITERS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WordWidth-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WordWidth-1:0]  out_data,
    output logic [RotWidth-1:0]   out_rot,
    output logic [CountWidth-1:0] out_count,
    output logic                  out_err
);

    localparam int unsigned IterWidth = (UNSHIFT_ITERS > 1) ? $clog2(UNSHIFT_ITERS) : 1;
    localparam logic [IterWidth-1:0]  IterLast = IterWidth'(UNSHIFT_ITERS - 1);
    localparam logic [IterWidth-1:0]  IterOne  = IterWidth'(1);
    localparam logic [RotWidth-1:0]   RotLast  = '1;
    localparam logic [RotWidth-1:0]   RotOne   = RotWidth'(1);
    localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

    perm_state_e state_q, state_d;

    logic [WordWidth-1:0]  y_q, y_d;
    logic [RotWidth-1:0]   r_q, r_d;
    logic [IterWidth-1:0]  k_q, k_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [RotWidth-1:0]   rot_q, rot_d;
    // cand_q is the selected (pre-unshift) candidate, held fixed through UNSHIFT;
    // x_q converges on the recovered word.
    logic [WordWidth-1:0]  cand_q, cand_d;
    logic [WordWidth-1:0]  x_q, x_d;

    logic [WordWidth-1:0]  cand;
    logic                  match;

    rotl64 u_rotl64 (
        .data    (y_q),
        .amt     (r_q),
        .rotated (cand)
    );

    // A candidate is self-consistent when its top field names the rotation that made it.
    assign match = (cand[WordWidth-1 -: RotWidth] == r_q);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        r_d     = r_q;
        k_d     = k_q;
        count_d = count_q;
        rot_d   = rot_q;
        cand_d  = cand_q;
        x_d     = x_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    y_d     = in_data;
                    r_d     = '0;
                    k_d     = '0;
                    count_d = '0;
                    rot_d   = '0;
                    cand_d  = '0;
                    x_d     = '0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                // Later matches overwrite earlier ones, so the degenerate r=0 match
                // loses to any other.
                if (match) begin
                    count_d = count_q + CountOne;
                    rot_d   = r_q;
                    cand_d  = cand;
                    x_d     = cand;
                end
                if (r_q == RotLast) begin
                    k_d     = '0;
                    state_d = StUnshift;
                end else begin
                    r_d = r_q + RotOne;
                end
            end
            StUnshift: begin
                // Top SHIFT bits are already correct; each pass fixes SHIFT more.
                x_d = cand_q ^ (x_q >> SHIFT);
                if (k_q == IterLast) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + IterOne;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            y_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            count_q <= '0;
            rot_q   <= '0;
            cand_q  <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            r_q     <= r_d;
            k_q     <= k_d;
            count_q <= count_d;
            rot_q   <= rot_d;
            cand_q  <= cand_d;
            x_q     <= x_d;
        end
    end

    // Outputs decode registered state only, and read as zero outside DONE.
    logic done;
    logic no_match;

    assign done     = (state_q == StDone);
    assign no_match = (count_q == '0);

    assign in_ready  = (state_q == StIdle);
    assign out_valid = done;
    assign out_err   = done && no_match;
    assign out_data  = (done && !no_match) ? x_q : '0;
    assign out_rot   = (done && !no_match) ? rot_q : '0;
    assign out_count = done ? count_q : '0;

endmodule

// File: tb/tb_perm_inverse.sv
// Randomized self-checking bench for perm_inverse against a bit-level reference model.
module tb_perm_inverse;

    localparam int SH      = 6;
    localparam int ITERS   = 10;
    localparam int LATENCY = 64 + ITERS;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [5:0]  out_rot;
    logic [6:0]  out_count;
    logic        out_err;

    int n_checks = 0;
    int n_fail   = 0;

    perm_inverse #(
        .SHIFT         (SH),
        .UNSHIFT_ITERS (ITERS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rot   (out_rot),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotl_ref(input logic [63:0] v, input int r);
        if (r == 0) return v;
        return (v << r) | (v >> (64 - r));
    endfunction

    // Forward output stage: xorshift, then rotate right by the original top field.
    function automatic logic [63:0] forward(input logic [63:0] x);
        logic [63:0] t;
        int          r;
        t = x ^ (x >> SH);
        r = int'(x[63:58]);
        if (r == 0) return t;
        return (t >> r) | (t << (64 - r));
    endfunction

    // Reference: try every rotation, keep the highest consistent one, then undo the
    // xorshift one bit at a time from the MSB down.
    function automatic void ref_model(input logic [63:0] y, output logic [63:0] x,
                                      output logic [5:0] rot, output logic [6:0] cnt);
        logic [63:0] c;
        logic [63:0] t;
        cnt = '0;
        rot = '0;
        t   = '0;
        for (int r = 0; r < 64; r++) begin
            c = rotl_ref(y, r);
            if (int'(c[63:58]) == r) begin
                cnt++;
                rot = 6'(r);
                t   = c;
            end
        end
        x = '0;
        for (int i = 63; i >= 0; i--) begin
            if (i + SH <= 63) x[i] = t[i] ^ x[i + SH];
            else              x[i] = t[i];
        end
        if (cnt == 0) x = '0;
    endfunction

    task automatic check_outputs(input string tag, input logic [63:0] y);
        logic [63:0] ex;
        logic [5:0]  er;
        logic [6:0]  ec;
        ref_model(y, ex, er, ec);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(1));
        check_eq({tag, ".data"},  out_data, ex);
        check_eq({tag, ".rot"},   64'(out_rot), 64'(er));
        check_eq({tag, ".count"}, 64'(out_count), 64'(ec));
        check_eq({tag, ".err"},   64'(out_err), 64'(ec == 0));
    endtask

    task automatic send(input logic [63:0] y);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_data  = y;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; bounded.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) begin
                check_eq({tag, ".busy_in_ready"}, 64'(in_ready), 64'(0));
            end
            if (out_valid) break;
        end
        check_eq({tag, ".latency"}, 64'(lat), 64'(LATENCY));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq({tag, ".hs_valid"}, 64'(out_valid), 64'(0));
        check_eq({tag, ".hs_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run_word(input string tag, input logic [63:0] y);
        send(y);
        wait_done(tag);
        check_outputs(tag, y);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(0));
        check_eq({tag, ".data"},  out_data, 64'(0));
        check_eq({tag, ".rot"},   64'(out_rot), 64'(0));
        check_eq({tag, ".count"}, 64'(out_count), 64'(0));
        check_eq({tag, ".err"},   64'(out_err), 64'(0));
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    endtask

    logic [63:0] y1;
    logic [63:0] y2;
    logic [63:0] ex;
    logic [5:0]  er;
    logic [6:0]  ec;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed words with hand-derived results.
        run_word("zero", 64'h0);
        check_eq("zero.k_data",  out_data, 64'h0);
        check_eq("zero.k_count", 64'(out_count), 64'd1);
        check_eq("zero.k_rot",   64'(out_rot), 64'd0);
        handshake("zero");

        run_word("two", 64'h0000_0000_8200_0000);
        check_eq("two.k_data",  out_data, 64'h8000_0000_0000_0000);
        check_eq("two.k_count", 64'(out_count), 64'd2);
        check_eq("two.k_rot",   64'(out_rot), 64'd32);
        handshake("two");

        run_word("wrap", 64'hFFE0_0000_0000_0001);
        check_eq("wrap.k_data", out_data, 64'hFC00_0000_0000_0000);
        check_eq("wrap.k_rot",  64'(out_rot), 64'd63);
        handshake("wrap");

        run_word("nomatch", 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("nomatch.k_err",   64'(out_err), 64'd1);
        check_eq("nomatch.k_count", 64'(out_count), 64'd0);
        check_eq("nomatch.k_data",  out_data, 64'h0);
        handshake("nomatch");

        // Backpressure with a second word offered while the first is held.
        y1 = 64'h0000_0000_8200_0000;
        y2 = forward({$urandom, $urandom});
        run_word("bp1", y1);
        ref_model(y1, ex, er, ec);
        in_valid = 1'b1;
        in_data  = y2;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp.hold_valid", 64'(out_valid), 64'(1));
            check_eq("bp.hold_data", out_data, ex);
            check_eq("bp.hold_rot", 64'(out_rot), 64'(er));
            check_eq("bp.hold_count", 64'(out_count), 64'(ec));
            check_eq("bp.hold_in_ready", 64'(in_ready), 64'(0));
        end
        handshake("bp1");
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done("bp2");
        check_outputs("bp2", y2);
        handshake("bp2");

        // Randomized words: raw, forward-permuted, and with a zero top field.
        for (int n = 0; n < 24; n++) begin
            int          mode;
            int          hold;
            logic [63:0] y;
            mode = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 3));
            y    = {$urandom, $urandom};
            if (mode == 1) y = forward(y);
            if (mode == 2) y[63:58] = 6'd0;
            run_word("rand", y);
            ref_model(y, ex, er, ec);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1 check_eq("rand.hold_data", out_data, ex);
            end
            handshake("rand");
        end

        // Reset mid-SEARCH, then a normal word.
        send(forward({$urandom, $urandom}));
        repeat (29) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_zero_outputs("rst_search");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_search.in_ready", 64'(in_ready), 64'(1));
        run_word("after_rst", 64'h0);
        handshake("after_rst");

        // Reset while a result is held in DONE.
        run_word("rst_done_word", 64'h0000_0000_8200_0000);
        #1 rst = 1'b0;
        #1 check_zero_outputs("rst_done");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_word("after_rst2", 64'hFFE0_0000_0000_0001);
        handshake("after_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perm_inverse.md
# perm_inverse

Inverse of the 64-bit output permutation stage: xorshift-by-6, then rotate right by the original top 6 bits. The block takes one permuted word and searches all 64 rotation amounts for a self-consistent candidate. It then undoes the xorshift iteratively and returns the recovered pre-permutation word. It sits beside the PRNG core as a verification and debug back-end, behind a valid/ready input and a valid/ready output.

## Interface
- `SHIFT`, default 6: xorshift distance; must equal the forward stage's shift.
- `UNSHIFT_ITERS`, default 10: fixed-point iterations; must be at least ceil(64/SHIFT)-1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  permuted word offered.
- `in_ready`  out  1  high only in IDLE.
- `in_data`  in  64  permuted word y.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  64  recovered word x; 0 when `out_err`.
- `out_rot`  out  6  selected rotation amount.
- `out_count`  out  7  number of matching rotation amounts, 0..64.
- `out_err`  out  1  no rotation matched.

## Operation
- State machine: IDLE -> SEARCH -> UNSHIFT -> DONE -> IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch y; clear r, count, the found flag and the candidate; go to SEARCH.
- **SEARCH**: one r per cycle, r = 0..63.
  - cand = rotl(y, r).
  - Match when cand[63:58]==r.
  - On each match: count+=1; store rot=r and x_reg=cand. Later matches overwrite earlier ones, so the highest r wins.
  - The r=0 match is degenerate and occurs whenever y[63:58]==0. The highest-r policy exists so that r=0 loses to any other match.
  - After r==63 is evaluated, go to UNSHIFT with iteration counter k=0.
  - The r counter is 6 bits and terminates on 63, never by wrap-around.
- **UNSHIFT**
  - Each cycle: x_reg = cand_sel ^ (x_reg >> SHIFT), with cand_sel held.
  - Runs UNSHIFT_ITERS cycles, then goes to DONE.
  - Each iteration adds SHIFT more correct MSBs. The top 6 bits start correct because the forward xorshift leaves them unchanged.
  - Runs even when count==0, so latency is constant.
- **DONE**
  - `out_valid`=1.
  - `out_data` = x_reg, or 0 if count==0.
  - `out_err` = (count==0). When `out_err`=1, `out_rot`=0.
  - On `out_ready`: go to IDLE. All outputs hold stable while `out_ready`=0.
- Only one word is in flight; no input is accepted before the DONE handshake completes.
- Reset
  - Asynchronous.
  - Asserting `rst` low at any point, mid-SEARCH or mid-UNSHIFT included, forces IDLE and discards the in-flight word.
  - Reset values: `in_ready`=1 (combinational from IDLE), `out_valid`=0, `out_data`=0, `out_rot`=0, `out_count`=0, `out_err`=0.

## Timing
- Accept edge E0.
- SEARCH evaluates on E1..E64.
- UNSHIFT runs on E65..E(64+UNSHIFT_ITERS).
- `out_valid` rises after E74 with defaults. Latency is 74 cycles, independent of data.
- Throughput: one word per 74 cycles plus output stall, plus one IDLE cycle.
- `in_ready` is low from the cycle after E0 until the cycle after the output handshake.
- Outputs are registered; no combinational path from `in_*` to `out_*`.

## Structure
- Shared PRNG package holds:
  - localparams: word width 64, rotation-field width 6, default SHIFT=6;
  - the FSM state enum.
- One natural sub-module: `rotl64`, a combinational left barrel rotator, reusable by the forward stage.
- Search and unshift logic stay in this module.

## Test plan
- y=64'h0 -> `out_valid` 74 cycles after accept; out_data=0, out_rot=0, out_count=1, out_err=0.
- y=64'h0000_0000_8200_0000 -> out_count=2 (r=0 and r=32); out_rot=32; out_data=64'h8000_0000_0000_0000.
- y=64'hFFE0_0000_0000_0001 (wrap case, r=63) -> out_rot=63, out_data=64'hFC00_0000_0000_0000.
- y=64'hFFFF_FFFF_FFFF_FFFE -> out_count=0, out_err=1, out_data=0, out_rot=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is ignored; after the handshake the second word is accepted and decoded correctly.
- Reset mid-operation: pull rst low at E30 of SEARCH -> immediately out_valid=0 and all outputs 0; after release in_ready=1, and the next word y=0 decodes with normal 74-cycle latency.
